prng_bank: RTL and testbench

- Parametrised bank of LANES independent Galois LFSR generators, each WIDTH bits, for wide random-word sources (test-pattern generators, dither, scramblers).
- A sequential seeding engine derives a distinct non-zero seed per lane from one input seed, one lane per cycle.
- It then runs a programmable warm-up and presents the concatenated lane states on a valid/ready stream.
- Only accepted words advance the generators, so back-pressure never drops or repeats a word.

---
 rtl/prng_pkg.sv | 14 +
 rtl/galois_lfsr_lane.sv | 17 +
 rtl/prng_bank.sv | 69 ++++++
 tb/tb_prng_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// prng_pkg: shared state enum, default Galois taps and lane-seed derivation for prng_bank (no ports)
package prng_pkg;
  typedef enum logic [1:0] {IDLE, SEED, WARM, RUN} state_t;
  localparam logic [3:0] TAPS4 = 4'hC;
  localparam logic [7:0] TAPS8 = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [31:0] TAPS32 = 32'h80200003;
  function automatic logic [63:0] lane_seed(input logic [63:0] seed, input int lane, input int width);
    logic [63:0] mask, v;
    mask = (width >= 64) ? '1 : (64'd1 << width) - 64'd1;
    v = (seed ^ 64'(lane + 1)) & mask;
    return (v == '0) ? mask : v;
  endfunction
endpackage

// File: rtl/galois_lfsr_lane.sv
// galois_lfsr_lane: one Galois LFSR lane register; in clk rst load load_val step, out state
module galois_lfsr_lane #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);
  always_ff @(posedge clk)
    if (rst) state <= '0;
    else if (load) state <= load_val;
    else if (step) state <= state[0] ? (state >> 1) ^ TAPS : state >> 1;
endmodule

// File: rtl/prng_bank.sv
// prng_bank: bank of LANES Galois LFSRs with seeding/warm-up FSM; in clk rst reseed seed out_ready, out out_valid out_data busy word_cnt
module prng_bank
  import prng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8),
  parameter int WARMUP = 2,
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reseed,
  input  logic [WIDTH-1:0]       seed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic                   busy,
  output logic [CNTW-1:0]        word_cnt
);
  localparam int LCW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int WCW = WARMUP > 1 ? $clog2(WARMUP) : 1;
  state_t state, state_n;
  logic [LCW-1:0] lc;
  logic [WCW-1:0] wc;
  logic [WIDTH-1:0] seed_q;
  logic accept, step, last_lane, last_warm;
  assign out_valid = state == RUN;
  assign busy = state == SEED || state == WARM;
  always_comb begin
    accept = out_valid && out_ready && !reseed;
    step = !reseed && (state == WARM || accept);
    last_lane = lc == LCW'(LANES - 1);
    last_warm = wc == WCW'(WARMUP - 1);
    state_n = reseed ? SEED :
              (state == SEED && last_lane) ? (WARMUP == 0 ? RUN : WARM) :
              (state == WARM && last_warm) ? RUN : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      lc <= '0;
      wc <= '0;
      word_cnt <= '0;
      seed_q <= '0;
    end else begin
      state <= state_n;
      if (reseed) begin
        seed_q <= seed;
        lc <= '0;
        wc <= '0;
        word_cnt <= '0;
      end else begin
        if (state == SEED) lc <= last_lane ? '0 : lc + 1'b1;
        if (state == WARM) wc <= last_warm ? '0 : wc + 1'b1;
        if (accept && word_cnt != '1) word_cnt <= word_cnt + 1'b1;
      end
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    galois_lfsr_lane #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (!reseed && state == SEED && lc == LCW'(i)),
      .load_val (WIDTH'(lane_seed(64'(seed_q), i, WIDTH))),
      .step     (step),
      .state    (out_data[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_prng_bank.sv
// tb_prng_bank: self-checking bench for prng_bank with a behavioural word-sequence model and directed vectors
module tb_prng_bank;
  localparam int W = 8;
  localparam int L = 4;
  localparam int WU = 2;
  localparam int LAT = L + WU;
  logic clk = 1'b0;
  logic rst, reseed, out_ready, reseed1, out_ready1;
  logic [W-1:0] seed, seed1;
  logic out_valid, busy, out_valid1, busy1;
  logic [W*L-1:0] out_data;
  logic [W-1:0] out_data1;
  logic [15:0] word_cnt;
  logic [1:0] word_cnt1;
  int n_cmp = 0;
  int n_bad = 0;
  bit go = 0;
  bit active = 0;
  int since = 0;
  int k = 0;
  logic [W-1:0] mseed = '0;
  logic [31:0] d;
  logic [15:0] c0;
  logic [7:0] seq1 [0:4];
  prng_bank dut (
    .clk(clk), .rst(rst), .reseed(reseed), .seed(seed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .word_cnt(word_cnt)
  );
  prng_bank #(.WIDTH(8), .LANES(1), .TAPS(8'hB8), .WARMUP(0), .CNTW(2)) dut1 (
    .clk(clk), .rst(rst), .reseed(reseed1), .seed(seed1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .busy(busy1), .word_cnt(word_cnt1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] stepf(input logic [7:0] s);
    return s[0] ? (s >> 1) ^ 8'hB8 : s >> 1;
  endfunction
  // Word after n generator steps: each lane starts from seed^(lane+1) (0 -> FF) and is stepped n times.
  function automatic logic [31:0] word_at(input logic [7:0] sd, input int n);
    logic [31:0] w;
    logic [7:0] s;
    for (int i = 0; i < L; i++) begin
      s = sd ^ 8'(i + 1);
      if (s == 8'h00) s = 8'hFF;
      for (int j = 0; j < n; j++) s = stepf(s);
      w[i*8 +: 8] = s;
    end
    return w;
  endfunction
  // Compare current outputs against the model, then advance the model with the inputs the next edge will see.
  initial forever begin
    @(negedge clk);
    if (go) begin
      chk("out_valid", 64'(out_valid), 64'(active && since == LAT));
      chk("busy", 64'(busy), 64'(active && since < LAT));
      chk("word_cnt", 64'(word_cnt), 64'(k > 65535 ? 65535 : k));
      if (active && since == LAT) chk("out_data", 64'(out_data), 64'(word_at(mseed, WU + k)));
      else if (!active) chk("out_data_idle", 64'(out_data), 64'd0);
    end
    if (rst) begin
      active = 0;
      since = 0;
      k = 0;
    end else if (reseed) begin
      active = 1;
      since = 0;
      k = 0;
      mseed = seed;
    end else if (active) begin
      if (since < LAT) since++;
      else if (out_ready) k++;
    end
  end
  initial begin
    seq1 = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    rst = 1; reseed = 0; seed = '0; out_ready = 0;
    reseed1 = 0; seed1 = '0; out_ready1 = 0;
    cyc();
    go = 1;
    cyc();
    rst = 0;
    repeat (10) cyc();
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_data", 64'(out_data), 64'd0);
    out_ready = 1; seed = 8'h00; reseed = 1;
    cyc();
    reseed = 0;
    chk("seed00_busy", 64'(busy), 64'd1);
    repeat (6) cyc();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_word", 64'(out_data), 64'h01E4B85C);
    chk("first_cnt", 64'(word_cnt), 64'd0);
    cyc();
    chk("second_word", 64'(out_data), 64'hB8725C2E);
    chk("second_cnt", 64'(word_cnt), 64'd1);
    repeat (2) cyc();
    c0 = word_cnt;
    out_ready = 1;
    cyc();
    out_ready = 0;
    d = out_data;
    cyc();
    chk("hold1", 64'(out_data), 64'(d));
    cyc();
    chk("hold2", 64'(out_data), 64'(d));
    out_ready = 1;
    cyc();
    chk("toggle_cnt", 64'(word_cnt), 64'(c0 + 16'd2));
    seed = 8'h03; reseed = 1;
    cyc();
    reseed = 0;
    repeat (4) cyc();
    chk("seed03_lanes", 64'(out_data), 64'h07FF0102);
    cyc();
    d = out_data;
    seed = 8'h5A; reseed = 1;
    cyc();
    reseed = 0;
    chk("warm_reseed_hold", 64'(out_data), 64'(d));
    chk("warm_reseed_cnt", 64'(word_cnt), 64'd0);
    repeat (5) cyc();
    chk("warm_relat_low", 64'(out_valid), 64'd0);
    cyc();
    chk("warm_relat_high", 64'(out_valid), 64'd1);
    repeat (3) cyc();
    d = out_data;
    seed = 8'hC3; reseed = 1;
    cyc();
    reseed = 0;
    chk("run_reseed_hold", 64'(out_data), 64'(d));
    chk("run_reseed_cnt", 64'(word_cnt), 64'd0);
    chk("run_reseed_valid", 64'(out_valid), 64'd0);
    repeat (6) cyc();
    chk("run_relat_high", 64'(out_valid), 64'd1);
    repeat (2) cyc();
    rst = 1; reseed = 1; seed = 8'h77;
    cyc();
    rst = 0; reseed = 0;
    chk("rst_reseed_data", 64'(out_data), 64'd0);
    chk("rst_reseed_busy", 64'(busy), 64'd0);
    cyc();
    chk("rst_reseed_idle", 64'(busy), 64'd0);
    seed = 8'h11; reseed = 1;
    cyc();
    reseed = 0;
    repeat (2) cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_seed_data", 64'(out_data), 64'd0);
    chk("rst_seed_busy", 64'(busy), 64'd0);
    repeat (3) cyc();
    seed1 = 8'h00; out_ready1 = 1; reseed1 = 1;
    cyc();
    reseed1 = 0;
    chk("l1_busy", 64'(busy1), 64'd1);
    chk("l1_valid_low", 64'(out_valid1), 64'd0);
    cyc();
    chk("l1_valid", 64'(out_valid1), 64'd1);
    chk("l1_word0", 64'(out_data1), 64'h01);
    chk("l1_cnt0", 64'(word_cnt1), 64'd0);
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("l1_word", 64'(out_data1), 64'(seq1[j]));
      chk("l1_cnt", 64'(word_cnt1), 64'(j + 1 > 3 ? 3 : j + 1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
